// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder
//
// Responder side of the core's data-memory port. It decodes the M-stage
// address into a byte-writable data RAM, a small MMIO window, or unmapped
// space. It returns the addressed word one cycle later on ReadData for the
// W stage.
//
// MMIO window (offset from MMIO_BASE):
//   0x00 LED       RW [15:0]         0x04 SW        RO {16'b0, sw_sync}
//   0x08 MTIME_LO  RW                0x0C MTIME_HI  RW
//   0x10 CMP_LO    RW                0x14 CMP_HI    RW
//   0x18 CTRL      RW bit0 timer enable, bit1 irq enable
//   0x1C STATUS    bit0 pending, write-1-to-clear through byte lane 0
//
// Ports:
//   clk, n_rst       clock; synchronous active-low reset
//   MemWriteM        write strobe for the address on ALUResult
//   ALUResult[31:0]  byte address (bits [1:0] do not select the word)
//   WriteData[31:0]  lane-aligned write data
//   Byte_Enable[3:0] per-lane write enables, used only when MemWriteM=1
//   ReadData[31:0]   registered word read at the previous cycle's address
//   sw[15:0]         asynchronous switch inputs
//   led[15:0]        LED register
//   timer_irq        registered timer interrupt request
//
// Access protocol: there is no valid/ready handshake. Every cycle is a read
// of ALUResult, and the word appears on ReadData after the next rising edge.
// A cycle with MemWriteM=1 also writes the enabled lanes at that same edge.
// The read samples the pre-write contents (read-first).

module dmem_mmio_responder #(
    parameter logic [31:0] DMEM_BASE  = 32'h1000_2000,
    parameter int          DMEM_WORDS = 2048,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int          PRESC      = 10
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic [3:0]  Byte_Enable,
    output logic [31:0] ReadData,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        timer_irq
);

    localparam int          AW         = $clog2(DMEM_WORDS);
    localparam logic [31:0] RAM_MASK   = 32'(DMEM_WORDS * 4 - 1);
    localparam int          PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    localparam logic [2:0] OFF_LED      = 3'd0;
    localparam logic [2:0] OFF_SW       = 3'd1;
    localparam logic [2:0] OFF_MTIME_LO = 3'd2;
    localparam logic [2:0] OFF_MTIME_HI = 3'd3;
    localparam logic [2:0] OFF_CMP_LO   = 3'd4;
    localparam logic [2:0] OFF_CMP_HI   = 3'd5;
    localparam logic [2:0] OFF_CTRL     = 3'd6;
    localparam logic [2:0] OFF_STATUS   = 3'd7;

    // Replace the lanes of old_w selected by be with the lanes of new_w.
    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic          ram_hit;
    logic          mmio_hit;
    logic [AW-1:0] word_idx;
    logic [2:0]    reg_off;
    logic          ram_we;
    logic          mmio_we;

    assign ram_hit  = (ALUResult & ~RAM_MASK) == DMEM_BASE;
    assign mmio_hit = ALUResult[31:5] == MMIO_BASE[31:5];
    assign word_idx = ALUResult[AW+1:2];
    assign reg_off  = ALUResult[4:2];
    // A write presented while reset is asserted is dropped.
    assign ram_we   = n_rst & MemWriteM & ram_hit;
    assign mmio_we  = MemWriteM & mmio_hit;

    // ------------------------------------------------------------------
    // Data RAM (contents are not reset)
    // ------------------------------------------------------------------
    logic [31:0] mem [DMEM_WORDS];
    logic [31:0] ram_rdata;

    assign ram_rdata = mem[word_idx];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (Byte_Enable[i]) mem[word_idx][8*i +: 8] <= WriteData[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [31:0]   read_data_q, read_data_d;
    logic [15:0]   led_q, led_d;
    logic [15:0]   sw_meta_q, sw_meta_d;
    logic [15:0]   sw_sync_q, sw_sync_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          pending_q, pending_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          timer_irq_q, timer_irq_d;

    logic        tick;
    logic        irq_set;
    logic        w1c;
    logic [63:0] mtime_inc;
    logic [31:0] mmio_rdata;

    always_comb begin
        read_data_d = '0;
        led_d       = led_q;
        sw_meta_d   = sw;
        sw_sync_d   = sw_meta_q;
        mtimecmp_d  = mtimecmp_q;
        ctrl_d      = ctrl_q;
        presc_d     = presc_q;
        tick        = 1'b0;
        w1c         = 1'b0;
        mmio_rdata  = '0;

        // Read mux, sampled from current (pre-write) register values.
        case (reg_off)
            OFF_LED:      mmio_rdata = {16'h0, led_q};
            OFF_SW:       mmio_rdata = {16'h0, sw_sync_q};
            OFF_MTIME_LO: mmio_rdata = mtime_q[31:0];
            OFF_MTIME_HI: mmio_rdata = mtime_q[63:32];
            OFF_CMP_LO:   mmio_rdata = mtimecmp_q[31:0];
            OFF_CMP_HI:   mmio_rdata = mtimecmp_q[63:32];
            OFF_CTRL:     mmio_rdata = {30'h0, ctrl_q};
            OFF_STATUS:   mmio_rdata = {31'h0, pending_q};
            default:      mmio_rdata = '0;
        endcase

        if (ram_hit)       read_data_d = ram_rdata;
        else if (mmio_hit) read_data_d = mmio_rdata;

        // Prescaler: a tick is the wrap of the count back to zero.
        if (ctrl_q[0]) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        // Increment first, then let written bytes override. The untouched
        // half therefore keeps the incremented value, including the carry.
        mtime_inc = mtime_q + {63'h0, tick};
        mtime_d   = mtime_inc;

        if (mmio_we) begin
            case (reg_off)
                OFF_LED: begin
                    if (Byte_Enable[0]) led_d[7:0]  = WriteData[7:0];
                    if (Byte_Enable[1]) led_d[15:8] = WriteData[15:8];
                end
                OFF_MTIME_LO: mtime_d[31:0]     = be_merge(mtime_inc[31:0], WriteData, Byte_Enable);
                OFF_MTIME_HI: mtime_d[63:32]    = be_merge(mtime_inc[63:32], WriteData, Byte_Enable);
                OFF_CMP_LO:   mtimecmp_d[31:0]  = be_merge(mtimecmp_q[31:0], WriteData, Byte_Enable);
                OFF_CMP_HI:   mtimecmp_d[63:32] = be_merge(mtimecmp_q[63:32], WriteData, Byte_Enable);
                OFF_CTRL: begin
                    if (Byte_Enable[0]) ctrl_d = WriteData[1:0];
                end
                OFF_STATUS:   w1c = Byte_Enable[0] & WriteData[0];
                default: ;
            endcase
        end

        // Set has priority over a simultaneous write-1-to-clear.
        irq_set     = ctrl_q[0] & (mtime_q >= mtimecmp_q);
        pending_d   = (pending_q & ~w1c) | irq_set;
        timer_irq_d = pending_d & ctrl_d[1];
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            read_data_q <= '0;
            led_q       <= '0;
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            ctrl_q      <= '0;
            pending_q   <= 1'b0;
            presc_q     <= '0;
            timer_irq_q <= 1'b0;
        end else begin
            read_data_q <= read_data_d;
            led_q       <= led_d;
            sw_meta_q   <= sw_meta_d;
            sw_sync_q   <= sw_sync_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            ctrl_q      <= ctrl_d;
            pending_q   <= pending_d;
            presc_q     <= presc_d;
            timer_irq_q <= timer_irq_d;
        end
    end

    assign ReadData  = read_data_q;
    assign led       = led_q;
    assign timer_irq = timer_irq_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder. A cycle-level behavioural model
// (word array, 64-bit counters, plain arithmetic) predicts ReadData, led and
// timer_irq. A negedge compare process checks those every cycle. Literal
// expectations at key points pin the model itself.

module tb_dmem_mmio_responder;

    localparam int PRESC = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst;
    logic        MemWriteM;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [3:0]  Byte_Enable;
    logic [15:0] sw;
    logic [31:0] ReadData;
    logic [15:0] led;
    logic        timer_irq;

    dmem_mmio_responder #(
        .DMEM_BASE  (32'h1000_2000),
        .DMEM_WORDS (2048),
        .MMIO_BASE  (32'hFFFF_0000),
        .PRESC      (PRESC)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .MemWriteM   (MemWriteM),
        .ALUResult   (ALUResult),
        .WriteData   (WriteData),
        .Byte_Enable (Byte_Enable),
        .ReadData    (ReadData),
        .sw          (sw),
        .led         (led),
        .timer_irq   (timer_irq)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [2048];
    logic [3:0]  m_kn  [2048];
    logic [15:0] m_led, m_s1, m_s2;
    logic [63:0] m_time, m_cmp;
    logic [1:0]  m_ctrl;
    logic        m_pend;
    int          m_pc;
    logic [31:0] e_rd;
    bit          e_rd_kn;
    logic [15:0] e_led;
    logic        e_irq;
    bit          model_live = 0;

    initial for (int i = 0; i < 2048; i++) m_kn[i] = 4'h0;

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] a, rd;
        logic [63:0] t_next;
        logic [2:0]  off;
        bit kn, rh, mh, tick, set, clr;
        int idx;
        model_live = 1;
        rd = 32'h0;
        kn = 1;
        if (!n_rst) begin
            m_led = 16'h0; m_s1 = 16'h0; m_s2 = 16'h0;
            m_time = 64'h0; m_cmp = '1; m_ctrl = 2'b00; m_pend = 1'b0; m_pc = 0;
            e_irq = 1'b0;
        end else begin
            a   = ALUResult;
            rh  = (a & ~32'h0000_1FFF) == 32'h1000_2000;
            mh  = (a >> 5) == (32'hFFFF_0000 >> 5);
            idx = int'(a[12:2]);
            off = a[4:2];
            if (rh) begin
                rd = m_ram[idx];
                kn = (m_kn[idx] == 4'hF);
            end else if (mh) begin
                case (off)
                    3'd0: rd = {16'h0, m_led};
                    3'd1: rd = {16'h0, m_s2};
                    3'd2: rd = m_time[31:0];
                    3'd3: rd = m_time[63:32];
                    3'd4: rd = m_cmp[31:0];
                    3'd5: rd = m_cmp[63:32];
                    3'd6: rd = {30'h0, m_ctrl};
                    default: rd = {31'h0, m_pend};
                endcase
            end
            tick = 0;
            if (m_ctrl[0]) begin
                m_pc = (m_pc + 1) % PRESC;
                tick = (m_pc == 0);
            end
            set    = m_ctrl[0] && (m_time >= m_cmp);
            t_next = m_time + (tick ? 64'd1 : 64'd0);
            clr    = 0;
            if (MemWriteM && rh) begin
                m_ram[idx] = lanes(m_ram[idx], WriteData, Byte_Enable);
                m_kn[idx]  = m_kn[idx] | Byte_Enable;
            end
            if (MemWriteM && mh) begin
                case (off)
                    3'd0: begin
                        if (Byte_Enable[0]) m_led[7:0]  = WriteData[7:0];
                        if (Byte_Enable[1]) m_led[15:8] = WriteData[15:8];
                    end
                    3'd2: t_next[31:0]  = lanes(t_next[31:0], WriteData, Byte_Enable);
                    3'd3: t_next[63:32] = lanes(t_next[63:32], WriteData, Byte_Enable);
                    3'd4: m_cmp[31:0]   = lanes(m_cmp[31:0], WriteData, Byte_Enable);
                    3'd5: m_cmp[63:32]  = lanes(m_cmp[63:32], WriteData, Byte_Enable);
                    3'd6: if (Byte_Enable[0]) m_ctrl = WriteData[1:0];
                    3'd7: clr = Byte_Enable[0] && WriteData[0];
                    default: ;
                endcase
            end
            m_time = t_next;
            m_s2   = m_s1;
            m_s1   = sw;
            m_pend = (m_pend && !clr) || set;
            e_irq  = m_pend && m_ctrl[1];
        end
        e_rd    = rd;
        e_rd_kn = kn;
        e_led   = m_led;
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (model_live) begin
            if (e_rd_kn) check("ReadData", ReadData, e_rd);
            check("led", {16'h0, led}, {16'h0, e_led});
            check("timer_irq", {31'h0, timer_irq}, {31'h0, e_irq});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        MemWriteM   = we;
        ALUResult   = addr;
        WriteData   = wd;
        Byte_Enable = be;
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        step(1'b1, addr, wd, be);
    endtask

    task automatic rd_lit(input logic [31:0] addr, input logic [31:0] exp, input string name);
        step(1'b0, addr, 32'h0, 4'h0);
        check(name, ReadData, exp);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        n_rst       = 1'b0;
        MemWriteM   = 1'b1;
        ALUResult   = 32'h1000_2000;
        WriteData   = 32'h2222_2222;
        Byte_Enable = 4'hF;
        sw          = 16'h0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_readdata", ReadData, 32'h0);
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_irq", {31'h0, timer_irq}, 32'h0);
        n_rst = 1'b1;
        rd_lit(32'hFFFF_0010, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd_lit(32'hFFFF_0014, 32'hFFFF_FFFF, "rst_cmp_hi");

        // byte writes
        wr(32'h1000_2004, 32'hDEAD_BEEF, 4'b1111);
        wr(32'h1000_2004, 32'h0000_5500, 4'b0010);
        wr(32'h1000_2004, 32'hFFFF_FFFF, 4'b0000);
        rd_lit(32'h1000_2004, 32'hDEAD_55EF, "byte_merge");

        // read-first
        wr(32'h1000_2008, 32'hCAFE_F00D, 4'hF);
        wr(32'h1000_2008, 32'h1234_5678, 4'hF);
        check("read_first_old", ReadData, 32'hCAFE_F00D);
        rd_lit(32'h1000_2008, 32'h1234_5678, "read_first_new");

        // top RAM word, then unmapped neighbours
        wr(32'h1000_3FFC, 32'hA5A5_0001, 4'hF);
        rd_lit(32'h1000_3FFC, 32'hA5A5_0001, "ram_top_word");
        wr(32'h2000_0000, 32'hFFFF_FFFF, 4'hF);
        rd_lit(32'h2000_0000, 32'h0, "unmapped_read");
        wr(32'h1000_4000, 32'h7777_7777, 4'hF);
        rd_lit(32'h1000_4000, 32'h0, "past_ram_end");
        rd_lit(32'hFFFE_FFFC, 32'h0, "below_mmio");

        // LED with partial enables
        wr(32'hFFFF_0000, 32'h0000_ABCD, 4'b0001);
        check("led_be0", {16'h0, led}, 32'h0000_00CD);
        wr(32'hFFFF_0000, 32'h1234_5678, 4'hF);
        rd_lit(32'hFFFF_0000, 32'h0000_5678, "led_readback");

        // switch synchronizer
        sw = 16'h5A5A;
        repeat (3) step(1'b0, 32'hFFFF_0004, 32'h0, 4'h0);
        rd_lit(32'hFFFF_0004, 32'h0000_5A5A, "sw_read");

        // reset mid-operation discards the concurrent write
        wr(32'h1000_2000, 32'h1111_1111, 4'hF);
        n_rst = 1'b0;
        step(1'b1, 32'h1000_2000, 32'h2222_2222, 4'hF);
        check("midrst_readdata", ReadData, 32'h0);
        check("midrst_led", {16'h0, led}, 32'h0);
        n_rst = 1'b1;
        rd_lit(32'h1000_2000, 32'h1111_1111, "reset_discards_write");

        // timer and interrupt
        wr(32'hFFFF_0010, 32'd5, 4'hF);
        wr(32'hFFFF_0014, 32'd0, 4'hF);
        wr(32'hFFFF_0018, 32'd3, 4'hF);
        repeat (3) step(1'b0, 32'hFFFF_0008, 32'h0, 4'h0);
        check("irq_before_cmp", {31'h0, timer_irq}, 32'h0);
        repeat (6) step(1'b0, 32'hFFFF_0008, 32'h0, 4'h0);
        check("irq_at_cmp", {31'h0, timer_irq}, 32'h1);
        wr(32'hFFFF_001C, 32'h1, 4'b0001);
        check("w1c_set_wins", {31'h0, timer_irq}, 32'h1);
        wr(32'hFFFF_0014, 32'h1, 4'hF);
        wr(32'hFFFF_001C, 32'h1, 4'b0001);
        check("irq_cleared", {31'h0, timer_irq}, 32'h0);
        repeat (4) step(1'b0, 32'hFFFF_001C, 32'h0, 4'h0);
        check("irq_stays_low", {31'h0, timer_irq}, 32'h0);

        // 64-bit wrap
        wr(32'hFFFF_0018, 32'h0, 4'hF);
        wr(32'hFFFF_0008, 32'hFFFF_FFFF, 4'hF);
        wr(32'hFFFF_000C, 32'hFFFF_FFFF, 4'hF);
        wr(32'hFFFF_0018, 32'h1, 4'hF);
        rd_lit(32'hFFFF_000C, 32'hFFFF_FFFF, "wrap_pre");
        rd_lit(32'hFFFF_000C, 32'h0, "wrap_hi");
        rd_lit(32'hFFFF_0008, 32'h1, "wrap_lo");

        // CPU write on a tick edge
        wr(32'hFFFF_0018, 32'h0, 4'hF);
        wr(32'hFFFF_0008, 32'hFFFF_FFFF, 4'hF);
        wr(32'hFFFF_000C, 32'h5, 4'hF);
        wr(32'hFFFF_0018, 32'h1, 4'hF);
        wr(32'hFFFF_0008, 32'h100, 4'hF);
        rd_lit(32'hFFFF_0008, 32'h100, "collide_lo");
        rd_lit(32'hFFFF_000C, 32'h6, "collide_carry_hi");
        wr(32'hFFFF_000C, 32'h7, 4'hF);
        rd_lit(32'hFFFF_000C, 32'h7, "collide_hi");

        repeat (3) step(1'b0, 32'h0, 32'h0, 4'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
